// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - control, configuration and status bundle for dds_sweep_ctrl
interface dds_sweep_ctrl_if #(
    parameter int W  = 8,
    parameter int DW = 16
);
    logic          start;
    logic          abort;
    logic          pause;
    logic [W-1:0]  cfg_start;
    logic [W-1:0]  cfg_stop;
    logic [W-1:0]  cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic          cfg_loop;
    logic [W-1:0]  mult;
    logic          acc_clr;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, pause, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_loop,
        input  mult, acc_clr, busy, done
    );

    modport slave (
        input  start, abort, pause, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_loop,
        output mult, acc_clr, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - stepped linear frequency sweep driving the DDS phase increment
// Loop-restart mode is built only when DDS_SWEEP_LOOP_EN is defined.
module dds_sweep_ctrl #(
    parameter int W  = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    dds_sweep_ctrl_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state;
    logic [W-1:0]  mult_q;
    logic          acc_clr_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] cnt;

    logic [W-1:0]  s_start;
    logic [W-1:0]  s_stop;
    logic [W-1:0]  s_step;
    logic [DW-1:0] s_reload;
    logic          s_down;

    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [W-1:0]  next_val;
    logic          advance;
    logic          loop_now;

`ifdef DDS_SWEEP_LOOP_EN
    logic          s_loop;
    assign loop_now = s_loop;
`else
    assign loop_now = 1'b0;
`endif

    assign sw.mult    = mult_q;
    assign sw.acc_clr = acc_clr_q;
    assign sw.busy    = busy_q;
    assign sw.done    = done_q;

    // Extra top bit catches carry/borrow so the value clamps at stop instead of wrapping.
    always_comb begin
        sum  = {1'b0, mult_q} + {1'b0, s_step};
        diff = {1'b0, mult_q} - {1'b0, s_step};
        if (s_down)
            next_val = (diff[W] || (diff[W-1:0] < s_stop)) ? s_stop : diff[W-1:0];
        else
            next_val = (sum > {1'b0, s_stop}) ? s_stop : sum[W-1:0];
    end

    // A terminal-count edge always advances; pause only freezes non-terminal counting.
    assign advance = ((state == RUN) && (!sw.pause || (cnt == '0))) ||
                     ((state == PAUSE) && !sw.pause);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mult_q    <= '0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt       <= '0;
            s_start   <= '0;
            s_stop    <= '0;
            s_step    <= '0;
            s_reload  <= '0;
            s_down    <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
            s_loop    <= 1'b0;
`endif
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sw.start && !sw.abort) begin
                        s_start   <= sw.cfg_start;
                        s_stop    <= sw.cfg_stop;
                        s_step    <= (sw.cfg_step == '0) ? W'(1) : sw.cfg_step;
                        s_reload  <= (sw.cfg_dwell == '0) ? '0 : sw.cfg_dwell - DW'(1);
                        s_down    <= (sw.cfg_stop < sw.cfg_start);
`ifdef DDS_SWEEP_LOOP_EN
                        s_loop    <= sw.cfg_loop;
`endif
                        cnt       <= (sw.cfg_dwell == '0) ? '0 : sw.cfg_dwell - DW'(1);
                        mult_q    <= sw.cfg_start;
                        acc_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN, PAUSE: begin
                    if (sw.abort) begin
                        mult_q <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= sw.pause ? PAUSE : RUN;
                        if (advance) begin
                            if (cnt != '0) begin
                                cnt <= cnt - DW'(1);
                            end else if (mult_q != s_stop) begin
                                mult_q <= next_val;
                                cnt    <= s_reload;
                            end else if (loop_now) begin
                                mult_q    <= s_start;
                                acc_clr_q <= 1'b1;
                                cnt       <= s_reload;
                            end else begin
                                mult_q <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - scoreboard bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [10:0] sb[$];
    logic [10:0] e;
    logic [10:0] got;

    dds_sweep_ctrl_if #(.W(8), .DW(16)) sw ();

    dds_sweep_ctrl #(.W(8), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        got = {sw.mult, sw.acc_clr, sw.busy, sw.done};
    endtask

    function automatic void push_exp(int m, bit c, bit b, bit d);
        logic [7:0] mv;
        mv = m[7:0];
        sb.push_back({mv, c, b, d});
    endfunction

    // Reference sweep: one entry per visible cycle, then the done cycle and one idle cycle.
    function automatic void gen_sweep(int s, int st, int stp, int dw, bit finish);
        int  v;
        bit  first;
        stp   = (stp == 0) ? 1 : stp;
        dw    = (dw == 0) ? 1 : dw;
        v     = s;
        first = 1'b1;
        forever begin
            for (int k = 0; k < dw; k++) push_exp(v, first && (k == 0), 1'b1, 1'b0);
            first = 1'b0;
            if (v == st) break;
            if (st >= s) v = (v + stp > st) ? st : v + stp;
            else         v = (v - stp < st) ? st : v - stp;
        end
        if (finish) begin
            push_exp(0, 1'b0, 1'b0, 1'b1);
            push_exp(0, 1'b0, 1'b0, 1'b0);
        end
    endfunction

    task automatic set_cfg(int s, int st, int stp, int dw);
        sw.cfg_start = 8'(s);
        sw.cfg_stop  = 8'(st);
        sw.cfg_step  = 8'(stp);
        sw.cfg_dwell = 16'(dw);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if (got !== 11'h000) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", got, 11'h000);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_up_sweep();
        set_cfg(10, 40, 10, 3);
        gen_sweep(10, 40, 10, 3, 1'b1);
        sw.start = 1'b1;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL up_sweep: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_clamp();
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin set_cfg(200, 255, 100, 1); gen_sweep(200, 255, 100, 1, 1'b1); end
            else        begin set_cfg(50, 5, 20, 1);     gen_sweep(50, 5, 20, 1, 1'b1);     end
            sw.start = 1'b1;
            while (sb.size() > 0) begin
                tick();
                sw.start = 1'b0;
                e = sb.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL clamp%0d: got %h expected %h", t, got, e);
                end
            end
        end
    endtask

    task automatic test_degenerate();
        set_cfg(3, 5, 0, 0);
        gen_sweep(3, 5, 1, 1, 1'b1);
        sw.start = 1'b1;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL degenerate: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_pause();
        int j;
        set_cfg(10, 40, 10, 4);
        for (int k = 0; k < 4; k++) push_exp(10, k == 0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) push_exp(20, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(30, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(40, 1'b0, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0, 1'b1);
        push_exp(0, 1'b0, 1'b0, 1'b0);
        sw.start = 1'b1;
        j = 0;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pause cyc %0d: got %h expected %h", j, got, e);
            end
            if (j == 6)  sw.pause = 1'b1;
            if (j == 11) sw.pause = 1'b0;
            j++;
        end
    endtask

    task automatic test_abort();
        int j;
        set_cfg(10, 40, 10, 3);
        for (int k = 0; k < 3; k++) push_exp(10, k == 0, 1'b1, 1'b0);
        push_exp(20, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push_exp(0, 1'b0, 1'b0, 1'b0);
        sw.start = 1'b1;
        j = 0;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
            sw.abort = (j == 3);
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %h expected %h", j, got, e);
            end
            j++;
        end
        sw.abort = 1'b0;
        for (int k = 0; k < 3; k++) push_exp(0, 1'b0, 1'b0, 1'b0);
        sw.start = 1'b1;
        sw.abort = 1'b1;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
            sw.abort = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL start_abort: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_reconfig();
        int j;
        set_cfg(10, 40, 10, 3);
        gen_sweep(10, 40, 10, 3, 1'b1);
        sw.start = 1'b1;
        j = 0;
        while (sb.size() > 0) begin
            tick();
            sw.start = (j == 5);
            if (j == 1) set_cfg(0, 15, 1, 1);
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reconfig cyc %0d: got %h expected %h", j, got, e);
            end
            j++;
        end
        sw.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int j;
        set_cfg(10, 40, 10, 3);
        for (int k = 0; k < 3; k++) push_exp(10, k == 0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) push_exp(0, 1'b0, 1'b0, 1'b0);
        sw.start = 1'b1;
        j = 0;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
            reset = (j == 2);
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", j, got, e);
            end
            j++;
        end
        reset = 1'b0;
    endtask

    task automatic test_loop();
        int j;
        set_cfg(1, 3, 1, 1);
        sw.cfg_loop = 1'b1;
`ifdef DDS_SWEEP_LOOP_EN
        for (int k = 0; k < 8; k++) push_exp((k % 3) + 1, (k % 3) == 0, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0, 1'b0);
`else
        gen_sweep(1, 3, 1, 1, 1'b1);
`endif
        sw.start = 1'b1;
        j = 0;
        while (sb.size() > 0) begin
            tick();
            sw.start = 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
            sw.abort = (j == 7);
`endif
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL loop cyc %0d: got %h expected %h", j, got, e);
            end
            j++;
        end
        sw.abort    = 1'b0;
        sw.cfg_loop = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        sw.start     = 1'b0;
        sw.abort     = 1'b0;
        sw.pause     = 1'b0;
        sw.cfg_loop  = 1'b0;
        set_cfg(0, 0, 0, 0);
        tick();
        test_reset();
        test_up_sweep();
        test_clamp();
        test_degenerate();
        test_pause();
        test_abort();
        test_reconfig();
        test_reset_mid();
        test_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase accumulator. Latches a start/stop/step/dwell configuration, then drives the accumulator's increment input (`mult`) through a stepped linear sweep, holding each increment value for a programmed number of clocks. It also pulses an accumulator-clear at sweep start and reports busy/done. It sits between the register/config front end and `phase_acc`.

## Interface
- `W`, default 8: increment width; matches the `mult` input of the phase accumulator.
- `DW`, default 16: dwell counter width.
- `clk`  in  1: system clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a sweep; sampled only in IDLE.
- `abort`  in  1: terminate the sweep immediately; honoured in every state.
- `pause`  in  1: level; freezes the dwell countdown while high.
- `cfg_start`  in  W: first increment value.
- `cfg_stop`  in  W: final increment value; `cfg_stop < cfg_start` selects a down-sweep.
- `cfg_step`  in  W: step magnitude; 0 is treated as 1.
- `cfg_dwell`  in  DW: clocks per increment value; 0 is treated as 1.
- `cfg_loop`  in  1: restart from `cfg_start` after the stop value (see Configuration).
- `mult`  out  W: increment to the phase accumulator.
- `acc_clr`  out  1: one-cycle pulse that clears the phase accumulator.
- `busy`  out  1: high in RUN and PAUSE.
- `done`  out  1: one-cycle pulse when a non-looping sweep completes.

## Operation
- The FSM has three states: IDLE, RUN and PAUSE.
- **IDLE → RUN** on `start & ~abort`. In the same edge:
  - latch all `cfg_*` into shadow registers
  - `mult <= cfg_start`, `acc_clr <= 1`, `busy <= 1`
  - dwell counter `<= max(cfg_dwell,1) - 1`
- Changing `cfg_*` during a sweep has no effect until the next start.
- **RUN**:
  - If the dwell counter is nonzero, decrement it.
  - If it is zero and `mult != stop`, load the next value into `mult` and reload the counter.
  - If it is zero and `mult == stop`, finish: either loop back (`mult <= start`, `acc_clr` pulse, counter reload) or terminate.
- **Terminate**: `mult <= 0`, `busy <= 0`, `done <= 1` for one cycle, go to IDLE.
- **RUN ↔ PAUSE**:
  - `pause` high in RUN moves to PAUSE. The counter and `mult` freeze and `mult` keeps driving.
  - `pause` low in PAUSE moves back to RUN, and the countdown resumes where it stopped.
- **Next-value arithmetic** is done in W+1 bits:
  - Up-sweep: `cur + step`; if the sum is greater than `stop` (including carry out of W bits), clamp to `stop`.
  - Down-sweep: `cur - step`; on borrow or a result below `stop`, clamp to `stop`.
  - `mult` never wraps and never overshoots `stop`.
- `cfg_start == cfg_stop`: one value is held for one dwell period, then the sweep finishes.
- **abort** in any state, one edge: `mult <= 0`, `busy <= 0`, go to IDLE. No `done` and no `acc_clr`.
- **Simultaneous events**:
  - `abort` beats `start`, `pause` and finish.
  - `pause` asserted on the terminal-count cycle does not block that transition. The value change or finish happens first, and PAUSE is entered on the next edge.
  - `start` while `busy` is ignored.
- **reset**: state IDLE; `mult`, `acc_clr`, `busy`, `done`, dwell counter and shadow registers all 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge N gives `mult = cfg_start`, `acc_clr = 1` and `busy = 1` visible after edge N.
- `acc_clr` is high for exactly one cycle.
- Each increment value is visible for exactly `max(cfg_dwell,1)` cycles when `pause` stays low. Each paused cycle adds one cycle.
- For a sweep of K values, `done` is visible after edge N + K·dwell, in the same cycle that `mult` returns to 0 and `busy` drops.
- A new `start` is accepted at the edge after `done`.
- In loop mode, `cfg_start` follows `cfg_stop` with no gap cycle and with an `acc_clr` pulse.

## Configuration
- Macro: `DDS_SWEEP_LOOP_EN`.
- Defined:
  - `cfg_loop` is honoured; a sweep with `cfg_loop = 1` repeats until `abort`.
  - `done` never pulses in loop mode.
- Undefined:
  - The `cfg_loop` port remains but is ignored; every sweep terminates.
  - No loop-restart logic is synthesised.

## Test plan
- **Up-sweep**: reset, then start with start=10, stop=40, step=10, dwell=3.
  - `mult` = 10,10,10,20,20,20,30,30,30,40,40,40, then 0.
  - `acc_clr` high in cycle 1 only; `done` pulses in cycle 13; `busy` high for cycles 1–12.
- **Clamp and overflow**:
  - start=200, stop=255, step=100, dwell=1 → `mult` = 200, 255, 0; no wrap.
  - start=50, stop=5, step=20 → 50, 30, 10, 5.
- **Degenerate configuration**: step=0, dwell=0, start=3, stop=5 → `mult` = 3, 4, 5, each for 1 cycle; then `done`.
- **Pause and abort**:
  - Dwell=4, `pause` high for 5 cycles during the value 20 → 20 is visible for 9 cycles.
  - `abort` asserted mid-dwell → `mult` = 0 and `busy` = 0 on the next cycle, with no `done`.
  - `start` and `abort` in the same IDLE cycle → the controller stays in IDLE.
- **Reconfiguration and reset**:
  - Change `cfg_stop` mid-sweep → no effect on the running sweep.
  - Assert `reset` mid-sweep → all outputs 0 on the next cycle.
  - `start` pulsed while busy → ignored.
- **Loop mode** (with `DDS_SWEEP_LOOP_EN`): `cfg_loop=1`, start=1, stop=3, step=1, dwell=1.
  - `mult` = 1,2,3,1,2,3…; `acc_clr` every 3rd cycle; `done` never pulses.
  - Without the macro, the same stimulus gives `done` after 3 values.
